// File: rtl/slow_access_ctl_pkg.sv
// Shared types and sizing for the slow-access window controller (package slow_pkg).
package slow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    function automatic int tick_w(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/slow_access_ctl_if.sv
// Bus-cycle decode, configuration inputs and slow-window outputs of slow_access_ctl.
interface slow_access_ctl_if;
    logic                        BACT;
    logic                        IACKCyc;
    logic                        VIACS;
    logic                        IWMCS;
    logic                        SCCCS;
    logic                        SCSICS;
    logic                        SndFetch;
    logic                        SlowIACK;
    logic                        SlowVIA;
    logic                        SlowIWM;
    logic                        SlowSCC;
    logic                        SlowSCSI;
    logic                        SlowSnd;
    logic                        SlowClockGate;
    logic [slow_pkg::CNT_W-1:0]  SlowTimeout;
    logic                        SlowReq;
    logic                        SlowHold;
    logic                        ClockGate;

    modport master (
        output BACT, IACKCyc, VIACS, IWMCS, SCCCS, SCSICS, SndFetch,
        output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
        output SlowClockGate, SlowTimeout,
        input  SlowReq, SlowHold, ClockGate
    );

    modport slave (
        input  BACT, IACKCyc, VIACS, IWMCS, SCCCS, SCSICS, SndFetch,
        input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
        input  SlowClockGate, SlowTimeout,
        output SlowReq, SlowHold, ClockGate
    );
endinterface

// File: rtl/slow_access_ctl_tick_prescaler.sv
// Divides CLK into one-cycle tick pulses every TICK_DIV cycles while run is high.
module slow_tick_prescaler
    import slow_pkg::*;
#(
    parameter int TICK_DIV = 16
) (
    input  logic CLK,
    input  logic nPOR,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int              TICK_W = tick_w(TICK_DIV);
    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count_r;

    // prescale counter, wraps after the terminal count
    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            count_r <= {TICK_W{1'b0}};
        end else if (clear) begin
            count_r <= {TICK_W{1'b0}};
        end else if (run) begin
            count_r <= (count_r == LAST) ? {TICK_W{1'b0}} : count_r + TICK_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = run & ~clear & (count_r == LAST);
endmodule

// File: rtl/slow_access_ctl.sv
// Slow-down window sequencer for legacy peripheral bus cycles and sound fetches.
// Optional clock-gate request output is enabled by defining SLOW_CLOCKGATE_EN.
module slow_access_ctl
    import slow_pkg::*;
#(
    parameter int TICK_DIV = 16
) (
    input  logic               CLK,
    input  logic               nPOR,
    slow_access_ctl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUS  = BUS;
    localparam logic [1:0] ST_HOLD = HOLD;

    logic             bactr_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] tmo_r;
    logic             slow_req_r;
    logic             slow_hold_r;

    logic             start_s;
    logic             hit_s;
    logic             snd_hit_s;
    logic             tick_s;
    logic             presc_clear_s;
    logic [1:0]       state_n_s;
    logic [CNT_W-1:0] cnt_n_s;
    logic [CNT_W-1:0] tmo_n_s;

    assign start_s = bus.BACT & ~bactr_r;
    assign hit_s   = start_s & ((bus.IACKCyc & bus.SlowIACK) | (bus.VIACS & bus.SlowVIA) |
                                (bus.IWMCS & bus.SlowIWM) | (bus.SCCCS & bus.SlowSCC) |
                                (bus.SCSICS & bus.SlowSCSI));
    // a zero-length sound window has nothing to hold, so it never counts as a hit
    assign snd_hit_s = bus.SndFetch & bus.SlowSnd & (bus.SlowTimeout != {CNT_W{1'b0}});

    slow_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .CLK   (CLK),
        .nPOR  (nPOR),
        .clear (presc_clear_s),
        .run   (state_r == ST_HOLD),
        .tick  (tick_s)
    );

    // window state machine: Hit beats SndHit beats tick decrement
    always_comb begin
        state_n_s     = state_r;
        cnt_n_s       = cnt_r;
        tmo_n_s       = tmo_r;
        presc_clear_s = (state_r != ST_HOLD);
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    state_n_s = ST_BUS;
                    tmo_n_s   = bus.SlowTimeout;
                end else if (snd_hit_s) begin
                    state_n_s = ST_HOLD;
                    cnt_n_s   = bus.SlowTimeout;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (hit_s) begin
                    tmo_n_s = bus.SlowTimeout;
                end else if (!bus.BACT) begin
                    if (tmo_r == {CNT_W{1'b0}}) begin
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_HOLD;
                        cnt_n_s   = tmo_r;
                    end
                end else begin
                    state_n_s = ST_BUS;
                end
            end
            ST_HOLD: begin
                if (hit_s) begin
                    state_n_s = ST_BUS;
                    tmo_n_s   = bus.SlowTimeout;
                end else if (snd_hit_s) begin
                    cnt_n_s       = bus.SlowTimeout;
                    presc_clear_s = 1'b1;
                end else if (tick_s) begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_n_s = ST_IDLE;
                        cnt_n_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_n_s = cnt_r - CNT_W'(1);
                    end
                end else begin
                    state_n_s = ST_HOLD;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // state, counters and outputs registered from the next state
    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            bactr_r     <= 1'b0;
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            tmo_r       <= {CNT_W{1'b0}};
            slow_req_r  <= 1'b0;
            slow_hold_r <= 1'b0;
        end else begin
            bactr_r     <= bus.BACT;
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            tmo_r       <= tmo_n_s;
            slow_req_r  <= (state_n_s != ST_IDLE);
            slow_hold_r <= (state_n_s == ST_HOLD);
        end
    end

    assign bus.SlowReq  = slow_req_r;
    assign bus.SlowHold = slow_hold_r;

`ifdef SLOW_CLOCKGATE_EN
    logic cg_lat_r;
    logic cg_n_s;
    logic clock_gate_r;

    // SndHit only opens or reloads a window outside BUS, so only then does it relatch
    always_comb begin
        cg_n_s = cg_lat_r;
        if (hit_s || (snd_hit_s && (state_r != ST_BUS))) begin
            cg_n_s = bus.SlowClockGate;
        end else begin
            cg_n_s = cg_lat_r;
        end
    end

    // latched gate enable and the registered gate request
    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            cg_lat_r     <= 1'b0;
            clock_gate_r <= 1'b0;
        end else begin
            cg_lat_r     <= cg_n_s;
            clock_gate_r <= (state_n_s != ST_IDLE) & cg_n_s;
        end
    end

    assign bus.ClockGate = clock_gate_r;
`else
    assign bus.ClockGate = 1'b0;
`endif
endmodule

// File: tb/tb_slow_access_ctl.sv
// Directed test-plan scenarios plus random traffic against a cycle-count window model.
module tb_slow_access_ctl;
    localparam int TICK_DIV = 16;

    logic clk = 1'b0;
    logic npor;
    always #5 clk = ~clk;

    slow_access_ctl_if bus();

    slow_access_ctl #(.TICK_DIV(TICK_DIV)) dut (
        .CLK  (clk),
        .nPOR (npor),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: a window is either tied to an open bus cycle or has hold cycles left
    bit m_bus;
    int m_left;
    int m_lat_t;
    bit m_lat_cg;
    bit m_bact_prev;

    int req_cnt, hold_cnt, cg_cnt, falls;
    bit prev_req;
    int bact_left;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit start, hit, snd;
        if (!npor) begin
            m_bus = 1'b0; m_left = 0; m_lat_t = 0; m_lat_cg = 1'b0; m_bact_prev = 1'b0;
        end else begin
            start = bus.BACT && !m_bact_prev;
            hit = start && ((bus.IACKCyc && bus.SlowIACK) || (bus.VIACS && bus.SlowVIA) ||
                            (bus.IWMCS && bus.SlowIWM) || (bus.SCCCS && bus.SlowSCC) ||
                            (bus.SCSICS && bus.SlowSCSI));
            snd = bus.SndFetch && bus.SlowSnd && (bus.SlowTimeout != 4'd0);
            if (hit) begin
                m_bus = 1'b1; m_left = 0; m_lat_t = int'(bus.SlowTimeout); m_lat_cg = bus.SlowClockGate;
            end else if (m_bus) begin
                if (!bus.BACT) begin
                    m_bus = 1'b0;
                    m_left = m_lat_t * TICK_DIV;
                end
            end else if (snd) begin
                m_left = int'(bus.SlowTimeout) * TICK_DIV;
                m_lat_cg = bus.SlowClockGate;
            end else if (m_left > 0) begin
                m_left--;
            end
            m_bact_prev = bus.BACT;
        end
    endtask

    task automatic step();
        bit exp_req, exp_cg;
        @(posedge clk);
        model_update();
        #1;
        exp_req = m_bus || (m_left > 0);
`ifdef SLOW_CLOCKGATE_EN
        exp_cg = exp_req && m_lat_cg;
`else
        exp_cg = 1'b0;
`endif
        chk("SlowReq", bus.SlowReq, exp_req);
        chk("SlowHold", bus.SlowHold, !m_bus && (m_left > 0));
        chk("ClockGate", bus.ClockGate, exp_cg);
        if (bus.SlowReq === 1'b1) req_cnt++;
        if (bus.SlowHold === 1'b1) hold_cnt++;
        if (bus.ClockGate === 1'b1) cg_cnt++;
        if (prev_req && bus.SlowReq !== 1'b1) falls++;
        prev_req = (bus.SlowReq === 1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        req_cnt = 0; hold_cnt = 0; cg_cnt = 0; falls = 0;
    endtask

    task automatic set_decode(input logic [4:0] dec);
        {bus.IACKCyc, bus.VIACS, bus.IWMCS, bus.SCCCS, bus.SCSICS} = dec;
    endtask

    task automatic set_en(input logic [5:0] en);
        {bus.SlowIACK, bus.SlowVIA, bus.SlowIWM, bus.SlowSCC, bus.SlowSCSI, bus.SlowSnd} = en;
    endtask

    task automatic bus_cycle(input logic [4:0] dec, input int len);
        bus.BACT = 1'b1; set_decode(dec);
        run(len);
        bus.BACT = 1'b0; set_decode(5'd0);
    endtask

    task automatic rand_drive();
        if (bact_left > 0) begin
            bact_left--;
        end else if (bus.BACT) begin
            bus.BACT = 1'b0; set_decode(5'd0);
        end else if ($urandom_range(0, 5) == 0) begin
            bus.BACT = 1'b1;
            bact_left = $urandom_range(0, 7);
            set_decode(5'($urandom_range(0, 31)));
        end
        if ($urandom_range(0, 19) == 0) begin
            set_en(6'($urandom));
            bus.SlowClockGate = 1'($urandom);
        end
        if ($urandom_range(0, 29) == 0) bus.SlowTimeout = 4'($urandom_range(0, 4));
        bus.SndFetch = ($urandom_range(0, 24) == 0);
        npor = ($urandom_range(0, 399) != 0);
    endtask

    initial begin
        npor = 1'b0;
        bus.BACT = 1'b0; set_decode(5'd0); bus.SndFetch = 1'b0;
        set_en(6'd0); bus.SlowClockGate = 1'b0; bus.SlowTimeout = 4'd0;
        prev_req = 1'b0; bact_left = 0;
        run(2);
        npor = 1'b1;

        // reset release, idle bus
        clear_counts();
        run(50);
        chk("idle_req", req_cnt, 0);

        // VIA hit, T=3, bus cycle of 10 clocks
        set_en(6'b010000); bus.SlowTimeout = 4'd3;
        clear_counts();
        bus_cycle(5'b01000, 10);
        run(70);
        chk("via_req_len", req_cnt, 10 + 3 * TICK_DIV);
        chk("via_hold_len", hold_cnt, 3 * TICK_DIV);

        // SCC disabled, then enabled with zero timeout
        set_en(6'b000000); bus.SlowTimeout = 4'd0;
        clear_counts();
        bus_cycle(5'b00010, 5);
        run(5);
        chk("scc_off_len", req_cnt, 0);
        set_en(6'b000100);
        clear_counts();
        bus_cycle(5'b00010, 5);
        run(5);
        chk("scc_t0_len", req_cnt, 5);
        chk("scc_t0_hold", hold_cnt, 0);

        // retrigger during HOLD
        set_en(6'b001000); bus.SlowTimeout = 4'd3;
        clear_counts();
        bus_cycle(5'b00100, 4);
        run(TICK_DIV + 8);
        bus_cycle(5'b00100, 3);
        run(70);
        chk("retrig_len", req_cnt, 4 + TICK_DIV + 8 + 3 + 3 * TICK_DIV);
        chk("retrig_gaps", falls, 1);

        // sound fetch, reload after 20 clocks
        set_en(6'b000001); bus.SlowTimeout = 4'd2;
        clear_counts();
        bus.SndFetch = 1'b1; run(1); bus.SndFetch = 1'b0;
        run(19);
        bus.SndFetch = 1'b1; run(1); bus.SndFetch = 1'b0;
        run(60);
        chk("snd_req_len", req_cnt, 20 + 2 * TICK_DIV);

        // reset in the middle of HOLD
        bus.SndFetch = 1'b1; run(1); bus.SndFetch = 1'b0;
        run(10);
        npor = 1'b0; run(1); npor = 1'b1;
        chk("rst_req", bus.SlowReq, 1'b0);
        chk("rst_hold", bus.SlowHold, 1'b0);
        run(5);

        // gate enable cleared mid-window
        set_en(6'b010000); bus.SlowTimeout = 4'd1; bus.SlowClockGate = 1'b1;
        clear_counts();
        bus.BACT = 1'b1; set_decode(5'b01000);
        run(3);
        bus.SlowClockGate = 1'b0;
        run(3);
        bus.BACT = 1'b0; set_decode(5'd0);
        run(30);
`ifdef SLOW_CLOCKGATE_EN
        chk("cg_track", cg_cnt, req_cnt);
`else
        chk("cg_track", cg_cnt, 0);
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rand_drive();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
